// File: rtl/sayeh_fetch_pkg.sv
// Shared definitions for the SAYEH instruction fetch sequencer.
// Holds the sequencer state encoding, the BranchSel code points, the
// wait-counter width and the BranchSel -> address-logic select decode.
package sayeh_fetch_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_t;

  // BranchSel code points: next-PC source chosen when an instruction is accepted
  localparam logic [1:0] BR_PC_PLUS1 = 2'b00;
  localparam logic [1:0] BR_PC_PLUSI = 2'b01;
  localparam logic [1:0] BR_R_PLUSI  = 2'b10;
  localparam logic [1:0] BR_R_PLUS0  = 2'b11;

  // Memory wait counter width (supports limits up to 255)
  localparam int WAIT_CNT_W = 8;

  // Address-logic select bundle, at most one bit set
  typedef struct packed {
    logic reset_pc;
    logic pc_plus1;
    logic pc_plus_i;
    logic r_plus_i;
    logic r_plus0;
  } addr_sel_t;

  // Map a BranchSel code to its single address-logic select
  function automatic addr_sel_t branch_select(input logic [1:0] code);
    addr_sel_t sel;
    sel = '0;
    case (code)
      BR_PC_PLUS1: sel.pc_plus1  = 1'b1;
      BR_PC_PLUSI: sel.pc_plus_i = 1'b1;
      BR_R_PLUSI:  sel.r_plus_i  = 1'b1;
      BR_R_PLUS0:  sel.r_plus0   = 1'b1;
      default:     sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer and memory.
//   MemAddr    : instruction address (sequencer -> memory)
//   MemReadReq : read request, held steady until MemReady (sequencer -> memory)
//   MemReady   : MemData valid this cycle (memory -> sequencer)
//   MemData    : instruction word (memory -> sequencer)
// master = fetch sequencer, slave = instruction memory.
interface fetch_sequencer_if;

  logic [15:0] MemAddr;
  logic        MemReadReq;
  logic        MemReady;
  logic [15:0] MemData;

  modport master (
    output MemAddr,
    output MemReadReq,
    input  MemReady,
    input  MemData
  );

  modport slave (
    input  MemAddr,
    input  MemReadReq,
    output MemReady,
    output MemData
  );

endinterface

// File: rtl/fetch_sequencer_chk.sv
// Protocol checker for the fetch sequencer (simulation assertions only).
// Ports: clk, ExternalReset, the five address-logic selects, the memory
// request/ready/address and the Fault flag, all observed read-only.
module fetch_sequencer_chk (
  input logic        clk,
  input logic        ExternalReset,
  input logic        ResetPC,
  input logic        PCplus1,
  input logic        PCplusI,
  input logic        RplusI,
  input logic        Rplus0,
  input logic        MemReadReq,
  input logic        MemReady,
  input logic [15:0] MemAddr,
  input logic        Fault
);

  logic [4:0] sels_s;
  assign sels_s = {ResetPC, PCplus1, PCplusI, RplusI, Rplus0};

  a_sel_onehot0: assert property (@(posedge clk) $onehot0(sels_s));

  a_no_sel_while_req: assert property (@(posedge clk) !(MemReadReq && (sels_s != 5'b00000)));

  // An unanswered request stays on the same address unless it times out
  a_req_steady: assert property (@(posedge clk) disable iff (ExternalReset)
    (MemReadReq && !MemReady) |=> (Fault || (MemReadReq && $stable(MemAddr))));

  a_fault_sticky: assert property (@(posedge clk) disable iff (ExternalReset)
    Fault |=> Fault);

endmodule

// File: rtl/fetch_sequencer.sv
// SAYEH instruction fetch sequencer.
// Drives the program counter through an external address-logic stage,
// fetches instruction words from memory and hands them to the decoder.
// Ports:
//   clk, ExternalReset       : clock, synchronous active-high reset
//   ALout / PCout            : address-logic result in / program counter out
//   ResetPC..Rplus0          : address-logic selects (at most one high)
//   mem (master)             : instruction memory read bus
//   IRout / IRvalid          : captured instruction and its valid flag
//   IRaccept / BranchSel     : decoder consume strobe and next-PC source
//   Fault                    : sticky memory-timeout flag
module fetch_sequencer
  import sayeh_fetch_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              ExternalReset,
  input  logic [15:0]       ALout,
  output logic [15:0]       PCout,
  output logic              ResetPC,
  output logic              PCplusI,
  output logic              PCplus1,
  output logic              RplusI,
  output logic              Rplus0,
  fetch_sequencer_if.master mem,
  output logic [15:0]       IRout,
  output logic              IRvalid,
  input  logic              IRaccept,
  input  logic [1:0]        BranchSel,
  output logic              Fault
);

  // Last counter value tolerated before the fetch is declared timed out
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LIMIT - 1);

  fetch_state_t            state_r;
  fetch_state_t            state_s;
  logic [WAIT_CNT_W-1:0]   wait_cnt_r;
  addr_sel_t               sel_s;
  logic                    read_req_s;
  logic                    capture_s;
  logic                    timeout_s;
  logic                    accept_s;

  // In FETCH the request is always up, so MemReady there is a real response
  assign capture_s = (state_r == ST_FETCH) && mem.MemReady;
  assign timeout_s = (state_r == ST_FETCH) && !mem.MemReady && (wait_cnt_r == WAIT_LAST);
  assign accept_s  = (state_r == ST_HOLD) && IRvalid && IRaccept;

  // State register
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (capture_s) begin
          state_s = ST_HOLD;
        end else if (timeout_s) begin
          state_s = ST_FAULT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Output decode: address-logic selects and memory request
  always_comb begin
    sel_s      = '0;
    read_req_s = 1'b0;
    if (ExternalReset) begin
      sel_s      = '0;
      read_req_s = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          sel_s.reset_pc = 1'b1;
        end
        ST_FETCH: begin
          read_req_s = 1'b1;
        end
        ST_HOLD: begin
          // BranchSel only matters in the accept cycle
          if (accept_s) begin
            sel_s = branch_select(BranchSel);
          end else begin
            sel_s = '0;
          end
        end
        ST_FAULT: begin
          sel_s      = '0;
          read_req_s = 1'b0;
        end
        default: begin
          sel_s      = '0;
          read_req_s = 1'b0;
        end
      endcase
    end
  end

  assign ResetPC        = sel_s.reset_pc;
  assign PCplus1        = sel_s.pc_plus1;
  assign PCplusI        = sel_s.pc_plus_i;
  assign RplusI         = sel_s.r_plus_i;
  assign Rplus0         = sel_s.r_plus0;
  assign mem.MemReadReq = read_req_s;
  assign mem.MemAddr    = PCout;

  // Program counter: loads ALout whenever a select is active (INIT or accept)
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      PCout <= 16'h0000;
    end else if (sel_s != '0) begin
      PCout <= ALout;
    end else begin
      PCout <= PCout;
    end
  end

  // Instruction register and its valid flag
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      IRout   <= 16'h0000;
      IRvalid <= 1'b0;
    end else if (capture_s) begin
      IRout   <= mem.MemData;
      IRvalid <= 1'b1;
    end else if (accept_s || (state_r == ST_FAULT)) begin
      IRvalid <= 1'b0;
    end else begin
      IRout   <= IRout;
      IRvalid <= IRvalid;
    end
  end

  // Memory wait counter: counts unanswered FETCH cycles, zero elsewhere
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_FETCH) && !mem.MemReady && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      Fault <= 1'b0;
    end else if (timeout_s) begin
      Fault <= 1'b1;
    end else begin
      Fault <= Fault;
    end
  end

  fetch_sequencer_chk u_chk (
    .clk           (clk),
    .ExternalReset (ExternalReset),
    .ResetPC       (ResetPC),
    .PCplus1       (PCplus1),
    .PCplusI       (PCplusI),
    .RplusI        (RplusI),
    .Rplus0        (Rplus0),
    .MemReadReq    (read_req_s),
    .MemReady      (mem.MemReady),
    .MemAddr       (PCout),
    .Fault         (Fault)
  );

endmodule
